// File: rtl/snake_pkg.sv
// Shared types for the snake game-step controller.
//   dir_t        : head direction encoding (UP=0, RIGHT=1, DOWN=2, LEFT=3)
//   game_state_t : game-state FSM encoding (IDLE=0, RUN=1, PAUSED=2, DEAD=3)
//   opposite()   : 180-degree reversal of a direction
package snake_pkg;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirRight = 2'd1,
        DirDown  = 2'd2,
        DirLeft  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        GsIdle   = 2'd0,
        GsRun    = 2'd1,
        GsPaused = 2'd2,
        GsDead   = 2'd3
    } game_state_t;

    // Opposite directions differ only in bit 1 of the encoding.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

endpackage

// File: rtl/snake_head_step.sv
// Combinational next-head-position calculator.
// Ports:
//   x_i, y_i  : current head column / row (row 0 = top)
//   dir_i     : direction of the move
//   x_o, y_o  : head position after one move (wrapped when WRAP=1)
//   oob_o     : move would leave the grid (only ever set when WRAP=0)
module snake_head_step
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W = 32,
    parameter int unsigned GRID_H = 24,
    parameter int unsigned X_W    = 5,
    parameter int unsigned Y_W    = 5,
    parameter int unsigned WRAP   = 1
) (
    input  logic [X_W-1:0] x_i,
    input  logic [Y_W-1:0] y_i,
    input  dir_t           dir_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           oob_o
);

    localparam logic [X_W-1:0] XMax = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] YMax = Y_W'(GRID_H - 1);
    localparam logic           Walled = (WRAP == 0);

    always_comb begin
        x_o   = x_i;
        y_o   = y_i;
        oob_o = 1'b0;
        unique case (dir_i)
            DirUp: begin
                if (y_i == '0) begin
                    y_o   = YMax;
                    oob_o = Walled;
                end else begin
                    y_o = y_i - Y_W'(1);
                end
            end
            DirDown: begin
                if (y_i == YMax) begin
                    y_o   = '0;
                    oob_o = Walled;
                end else begin
                    y_o = y_i + Y_W'(1);
                end
            end
            DirLeft: begin
                if (x_i == '0) begin
                    x_o   = XMax;
                    oob_o = Walled;
                end else begin
                    x_o = x_i - X_W'(1);
                end
            end
            DirRight: begin
                if (x_i == XMax) begin
                    x_o   = '0;
                    oob_o = Walled;
                end else begin
                    x_o = x_i + X_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/snake_step_ctrl.sv
// Snake game-step controller: prescales divider ticks into head moves,
// latches direction requests (rejecting reversals) and runs the game FSM.
// Ports:
//   clk_i, reset_i  : clock, synchronous active-high reset
//   tick_i          : one-cycle pulse from the clock divider
//   start_i         : level; IDLE->RUN, DEAD->re-init->RUN
//   pause_i         : level; holds RUN in PAUSED
//   key_valid_i     : direction request strobe, key_dir_i = requested dir
//   collide_i       : body/obstacle hit from the collision checker
//   head_x_o/_y_o   : current head position
//   dir_o           : committed direction
//   step_pulse_o    : one cycle, coincident with the updated head
//   state_o         : game state (IDLE/RUN/PAUSED/DEAD)
//   step_count_o    : moves since start, saturating
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W         = 32,
    parameter int unsigned GRID_H         = 24,
    parameter int unsigned X_W            = 5,
    parameter int unsigned Y_W            = 5,
    parameter int unsigned TICKS_PER_STEP = 4,
    parameter int unsigned START_X        = 16,
    parameter int unsigned START_Y        = 12,
    parameter int unsigned WRAP           = 1
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           tick_i,
    input  logic           start_i,
    input  logic           pause_i,
    input  logic           key_valid_i,
    input  logic [1:0]     key_dir_i,
    input  logic           collide_i,
    output logic [X_W-1:0] head_x_o,
    output logic [Y_W-1:0] head_y_o,
    output logic [1:0]     dir_o,
    output logic           step_pulse_o,
    output logic [1:0]     state_o,
    output logic [15:0]    step_count_o
);

    localparam logic [1:0] StIdle   = GsIdle;
    localparam logic [1:0] StRun    = GsRun;
    localparam logic [1:0] StPaused = GsPaused;
    localparam logic [1:0] StDead   = GsDead;

    localparam int unsigned    TcW    = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [TcW-1:0] TcMax  = TcW'(TICKS_PER_STEP - 1);
    localparam logic [X_W-1:0] InitX  = X_W'(START_X);
    localparam logic [Y_W-1:0] InitY  = Y_W'(START_Y);

    logic [1:0]     state_q, state_d;
    logic [X_W-1:0] head_x_q, head_x_d;
    logic [Y_W-1:0] head_y_q, head_y_d;
    dir_t           dir_q, dir_d;
    dir_t           pend_q, pend_d;
    logic [TcW-1:0] tick_cnt_q, tick_cnt_d;
    logic           step_pulse_q, step_pulse_d;
    logic [15:0]    step_count_q, step_count_d;

    logic [X_W-1:0] nxt_x;
    logic [Y_W-1:0] nxt_y;
    logic           nxt_oob;
    logic           key_ok;
    logic           qual_tick;

    // The move always uses the pending direction, which becomes the committed one.
    snake_head_step #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .X_W    (X_W),
        .Y_W    (Y_W),
        .WRAP   (WRAP)
    ) u_head_step (
        .x_i   (head_x_q),
        .y_i   (head_y_q),
        .dir_i (pend_q),
        .x_o   (nxt_x),
        .y_o   (nxt_y),
        .oob_o (nxt_oob)
    );

    // Reversal is judged against the committed direction, not the pending one.
    assign key_ok    = key_valid_i && (dir_t'(key_dir_i) != opposite(dir_q));
    assign qual_tick = tick_i && (tick_cnt_q == TcMax);

    always_comb begin
        state_d      = state_q;
        head_x_d     = head_x_q;
        head_y_d     = head_y_q;
        dir_d        = dir_q;
        pend_d       = pend_q;
        tick_cnt_d   = tick_cnt_q;
        step_pulse_d = 1'b0;
        step_count_d = step_count_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StRun;
                    tick_cnt_d = '0;
                end
            end
            StRun: begin
                if (key_ok) begin
                    pend_d = dir_t'(key_dir_i);
                end
                // Priority: collision, then pause, then tick handling.
                if (collide_i) begin
                    state_d = StDead;
                end else if (pause_i) begin
                    state_d = StPaused;
                end else if (tick_i) begin
                    if (qual_tick) begin
                        tick_cnt_d = '0;
                        if (nxt_oob) begin
                            state_d = StDead;
                        end else begin
                            head_x_d     = nxt_x;
                            head_y_d     = nxt_y;
                            dir_d        = pend_q;
                            step_pulse_d = 1'b1;
                            if (step_count_q != 16'hFFFF) begin
                                step_count_d = step_count_q + 16'd1;
                            end
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TcW'(1);
                    end
                end
            end
            StPaused: begin
                if (key_ok) begin
                    pend_d = dir_t'(key_dir_i);
                end
                if (!pause_i) begin
                    state_d = StRun;
                end
            end
            StDead: begin
                if (start_i) begin
                    state_d      = StRun;
                    head_x_d     = InitX;
                    head_y_d     = InitY;
                    dir_d        = DirRight;
                    pend_d       = DirRight;
                    tick_cnt_d   = '0;
                    step_count_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            head_x_q     <= InitX;
            head_y_q     <= InitY;
            dir_q        <= DirRight;
            pend_q       <= DirRight;
            tick_cnt_q   <= '0;
            step_pulse_q <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            head_x_q     <= head_x_d;
            head_y_q     <= head_y_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            tick_cnt_q   <= tick_cnt_d;
            step_pulse_q <= step_pulse_d;
            step_count_q <= step_count_d;
        end
    end

    assign head_x_o     = head_x_q;
    assign head_y_o     = head_y_q;
    assign dir_o        = dir_q;
    assign step_pulse_o = step_pulse_q;
    assign state_o      = state_q;
    assign step_count_o = step_count_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl. Two instances share all inputs: dut
// (WRAP=1) and dut_nw (WRAP=0); they diverge only when the head hits an edge.
module tb_snake_step_ctrl;

    logic        clk = 1'b0;
    logic        reset, tick, start, pause, key_valid, collide;
    logic [1:0]  key_dir;

    logic [4:0]  head_x, head_y, nw_head_x, nw_head_y;
    logic [1:0]  dir, state, nw_dir, nw_state;
    logic        step_pulse, nw_step_pulse;
    logic [15:0] step_count, nw_step_count;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;
    int p0;

    always #5 clk = ~clk;

    snake_step_ctrl #(.WRAP(1)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .tick_i       (tick),
        .start_i      (start),
        .pause_i      (pause),
        .key_valid_i  (key_valid),
        .key_dir_i    (key_dir),
        .collide_i    (collide),
        .head_x_o     (head_x),
        .head_y_o     (head_y),
        .dir_o        (dir),
        .step_pulse_o (step_pulse),
        .state_o      (state),
        .step_count_o (step_count)
    );

    snake_step_ctrl #(.WRAP(0)) dut_nw (
        .clk_i        (clk),
        .reset_i      (reset),
        .tick_i       (tick),
        .start_i      (start),
        .pause_i      (pause),
        .key_valid_i  (key_valid),
        .key_dir_i    (key_dir),
        .collide_i    (collide),
        .head_x_o     (nw_head_x),
        .head_y_o     (nw_head_y),
        .dir_o        (nw_dir),
        .step_pulse_o (nw_step_pulse),
        .state_o      (nw_state),
        .step_count_o (nw_step_count)
    );

    always @(negedge clk) if (step_pulse) pulse_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Pulse tick for one cycle; returns on the negedge where the result is visible.
    task automatic tick_once();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_once();
            @(negedge clk);
        end
    endtask

    task automatic press(input logic [1:0] d);
        key_valid = 1'b1;
        key_dir   = d;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0;
        key_valid = 1'b0; key_dir = 2'd0; collide = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_x", 32'(head_x), 16);
        check_eq("rst_y", 32'(head_y), 12);
        check_eq("rst_dir", 32'(dir), 1);
        check_eq("rst_cnt", 32'(step_count), 0);
        check_eq("rst_pulse", 32'(step_pulse), 0);

        // Ticks in IDLE are ignored.
        ticks(4);
        check_eq("idle_x", 32'(head_x), 16);
        check_eq("idle_pulse_cnt", 32'(pulse_cnt), 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_run", 32'(state), 1);

        // Eight ticks -> two steps, one cycle after ticks 4 and 8.
        p0 = pulse_cnt;
        for (int i = 1; i <= 8; i++) begin
            tick_once();
            if (i == 4) begin
                check_eq("t4_pulse", 32'(step_pulse), 1);
                check_eq("t4_x", 32'(head_x), 17);
                check_eq("t4_y", 32'(head_y), 12);
            end else if (i == 8) begin
                check_eq("t8_pulse", 32'(step_pulse), 1);
                check_eq("t8_x", 32'(head_x), 18);
            end else begin
                check_eq("tn_pulse", 32'(step_pulse), 0);
            end
            @(negedge clk);
            if (i == 4) check_eq("t4_pulse_1cyc", 32'(step_pulse), 0);
        end
        check_eq("t8_pulses", 32'(pulse_cnt - p0), 2);
        check_eq("t8_cnt", 32'(step_count), 2);

        // LEFT is a reversal of RIGHT (rejected); UP is accepted.
        press(2'd3);
        press(2'd0);
        ticks(3);
        tick_once();
        check_eq("up_pulse", 32'(step_pulse), 1);
        check_eq("up_x", 32'(head_x), 18);
        check_eq("up_y", 32'(head_y), 11);
        check_eq("up_dir", 32'(dir), 0);
        @(negedge clk);
        check_eq("up_cnt", 32'(step_count), 3);

        // Pause with two ticks already counted; only two more needed after release.
        ticks(2);
        pause = 1'b1;
        @(negedge clk);
        check_eq("pause_state", 32'(state), 2);
        p0 = pulse_cnt;
        ticks(10);
        check_eq("pause_no_pulse", 32'(pulse_cnt - p0), 0);
        check_eq("pause_y", 32'(head_y), 11);
        pause = 1'b0;
        @(negedge clk);
        check_eq("resume_state", 32'(state), 1);
        tick_once();
        check_eq("resume_t3_pulse", 32'(step_pulse), 0);
        @(negedge clk);
        tick_once();
        check_eq("resume_t4_pulse", 32'(step_pulse), 1);
        check_eq("resume_y", 32'(head_y), 10);
        @(negedge clk);

        // Pause coinciding with a qualifying tick: pause wins, count held.
        ticks(3);
        pause = 1'b1;
        tick_once();
        check_eq("pq_pulse", 32'(step_pulse), 0);
        check_eq("pq_state", 32'(state), 2);
        check_eq("pq_y", 32'(head_y), 10);
        @(negedge clk);
        pause = 1'b0;
        @(negedge clk);
        tick_once();
        check_eq("pq_after_pulse", 32'(step_pulse), 1);
        check_eq("pq_after_y", 32'(head_y), 9);
        @(negedge clk);
        check_eq("pq_cnt", 32'(step_count), 5);

        // Collide with a qualifying tick: DEAD, no move.
        ticks(3);
        collide = 1'b1;
        tick_once();
        collide = 1'b0;
        check_eq("col_state", 32'(state), 3);
        check_eq("col_pulse", 32'(step_pulse), 0);
        check_eq("col_x", 32'(head_x), 18);
        check_eq("col_y", 32'(head_y), 9);
        @(negedge clk);
        ticks(4);
        check_eq("dead_hold_y", 32'(head_y), 9);
        check_eq("dead_hold_cnt", 32'(step_count), 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("restart_state", 32'(state), 1);
        check_eq("restart_x", 32'(head_x), 16);
        check_eq("restart_y", 32'(head_y), 12);
        check_eq("restart_dir", 32'(dir), 1);
        check_eq("restart_cnt", 32'(step_count), 0);

        // Walk RIGHT to the edge, then step across it.
        for (int s = 0; s < 15; s++) ticks(4);
        check_eq("edge_x", 32'(head_x), 31);
        check_eq("edge_nw_x", 32'(nw_head_x), 31);
        check_eq("edge_nw_state", 32'(nw_state), 1);
        ticks(3);
        tick_once();
        check_eq("wrap_x", 32'(head_x), 0);
        check_eq("wrap_pulse", 32'(step_pulse), 1);
        check_eq("wall_state", 32'(nw_state), 3);
        check_eq("wall_x", 32'(nw_head_x), 31);
        check_eq("wall_pulse", 32'(nw_step_pulse), 0);
        @(negedge clk);
        check_eq("wrap_cnt", 32'(step_count), 16);
        check_eq("wall_cnt", 32'(nw_step_count), 15);

        // Reset together with a qualifying tick: no step, back to IDLE.
        ticks(3);
        tick  = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        tick  = 1'b0;
        reset = 1'b0;
        check_eq("rq_pulse", 32'(step_pulse), 0);
        check_eq("rq_state", 32'(state), 0);
        check_eq("rq_x", 32'(head_x), 16);
        check_eq("rq_cnt", 32'(step_count), 0);
        check_eq("rq_nw_state", 32'(nw_state), 0);

        // Reset one cycle after a qualifying tick clears the pulse.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ticks(3);
        tick_once();
        check_eq("ra_pulse_before", 32'(step_pulse), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("ra_pulse", 32'(step_pulse), 0);
        check_eq("ra_state", 32'(state), 0);
        check_eq("ra_x", 32'(head_x), 16);
        check_eq("ra_y", 32'(head_y), 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
